// File: rtl/speed_tick_pkg.sv
// Shared constants and the period helper for the LED-bouncer speed tick generator.
package speed_tick_pkg;

  localparam int NUM_SW           = 10;
  localparam int LEVEL_W          = 4;
  localparam int MAX_LEVEL        = 10;
  localparam int PERIOD_UNITS_MAX = 11;
  localparam int PKG_CNT_W        = 24;

  // Level 0 is the slowest (11 units), level 10 the fastest (1 unit).
  function automatic logic [PKG_CNT_W-1:0] period_of(
    input logic [LEVEL_W-1:0]   level,
    input logic [PKG_CNT_W-1:0] base
  );
    logic [LEVEL_W-1:0] units;
    units = LEVEL_W'(PERIOD_UNITS_MAX) - level;
    return PKG_CNT_W'(units) * base;
  endfunction

endpackage

// File: rtl/speed_tick_gen_debounce_bit.sv
// Two-flop synchroniser followed by a counting debouncer for one raw input bit.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DB_W            = 20
) (
  input  logic CLOCK_50,
  input  logic RESET,
  input  logic din,
  output logic dout
);

  logic            sync1_q, sync2_q;
  logic            stored_q, stored_d;
  logic [DB_W-1:0] cnt_q, cnt_d;

  always_comb begin
    stored_d = stored_q;
    cnt_d    = '0;
    if (sync2_q != stored_q) begin
      // The input must differ for DEBOUNCE_CYCLES consecutive cycles before we accept it.
      if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        stored_d = ~stored_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stored_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= din;
      sync2_q  <= sync1_q;
      stored_q <= stored_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout = stored_q;

endmodule

// File: rtl/speed_tick_gen.sv
// Debounced speed switches -> priority level -> periodic one-cycle step strobe.
// Optional KEY[1] pause toggle is built when SPEED_TICK_GEN_PAUSE_EN is defined.
module speed_tick_gen
  import speed_tick_pkg::*;
#(
  parameter int BASE_PERIOD     = 1000000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 24,
  parameter int DB_W            = 20
) (
  input  logic               CLOCK_50,
  input  logic               RESET,
  input  logic [NUM_SW-1:0]  SW,
  input  logic [1:0]         KEY,
  output logic               tick,
  output logic [LEVEL_W-1:0] level,
  output logic [NUM_SW-1:0]  sw_db
);

  logic [NUM_SW-1:0]  sw_db_w;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   period_w;
  logic               tick_q, tick_d;
  logic               freeze_w;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SW; gi++) begin : g_sw_db
      debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .DB_W           (DB_W)
      ) u_db (
        .CLOCK_50(CLOCK_50),
        .RESET   (RESET),
        .din     (SW[gi]),
        .dout    (sw_db_w[gi])
      );
    end
  endgenerate

`ifdef SPEED_TICK_GEN_PAUSE_EN
  logic key_db_w;
  logic key_prev_q;
  logic paused_q, paused_d;
  logic press_w;
  logic unused_key;

  assign unused_key = KEY[0];

  debounce_bit #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DB_W           (DB_W)
  ) u_key_db (
    .CLOCK_50(CLOCK_50),
    .RESET   (RESET),
    .din     (KEY[1]),
    .dout    (key_db_w)
  );

  // KEY is active-low, so a press is a debounced 1 -> 0 transition.
  always_comb begin
    press_w  = key_prev_q & ~key_db_w;
    paused_d = paused_q ^ press_w;
    freeze_w = paused_q | press_w;
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      key_prev_q <= 1'b0;
      paused_q   <= 1'b0;
    end else begin
      key_prev_q <= key_db_w;
      paused_q   <= paused_d;
    end
  end
`else
  logic unused_key;
  assign unused_key = ^KEY;
  assign freeze_w   = 1'b0;
`endif

  // Lowest-index switch wins, so scan from the top and let later hits override.
  always_comb begin
    level_d = '0;
    for (int k = NUM_SW - 1; k >= 0; k--) begin
      if (sw_db_w[k]) level_d = LEVEL_W'(k + 1);
    end
  end

  assign period_w = CNT_W'(period_of(level_q, PKG_CNT_W'(BASE_PERIOD)));

  // A new, shorter period takes effect at once; an overshot count fires on the next edge.
  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    tick_d = 1'b0;
    if (cnt_q >= period_w - 1'b1) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
    if (freeze_w) begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      level_q <= '0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
    end
  end

  assign tick  = tick_q;
  assign level = level_q;
  assign sw_db = sw_db_w;

endmodule

// File: tb/tb_speed_tick_gen.sv
// Directed bench for speed_tick_gen with BASE_PERIOD=10, DEBOUNCE_CYCLES=4.
module tb_speed_tick_gen;

  logic       clk = 1'b0;
  logic       RESET;
  logic [9:0] SW;
  logic [1:0] KEY;
  wire        tick;
  wire  [3:0] level;
  wire  [9:0] sw_db;

  int checks = 0;
  int errors = 0;
  int gap;
  int seen;

  always #5 clk = ~clk;

  speed_tick_gen #(
    .BASE_PERIOD    (10),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (24),
    .DB_W           (20)
  ) dut (
    .CLOCK_50(clk),
    .RESET   (RESET),
    .SW      (SW),
    .KEY     (KEY),
    .tick    (tick),
    .level   (level),
    .sw_db   (sw_db)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycles until the next tick; bounded so a dead DUT still reaches the summary.
  task automatic next_tick(output int g);
    g = 0;
    do begin
      step();
      g++;
    end while (!tick && g < 400);
  endtask

  task automatic quiet(input int n, output int s);
    s = 0;
    repeat (n) begin
      step();
      if (tick) s++;
    end
  endtask

  initial begin
    RESET = 1'b1;
    SW    = '0;
    KEY   = 2'b11;
    step();
    step();
    check("reset_tick", tick, 0);
    check("reset_level", level, 0);
    check("reset_sw_db", sw_db, 0);
    $display("reset: tick=%0d level=%0d sw_db=%h", tick, level, sw_db);

    // 1: all switches off -> period 110, first tick on edge 110 after release
    RESET = 1'b0;
    quiet(109, seen);
    check("t1_quiet", seen, 0);
    step();
    check("t1_first_tick", tick, 1);
    step();
    check("t1_width", tick, 0);
    next_tick(gap);
    check("t1_period", gap, 109);
    $display("t1: idle period gap=%0d level=%0d", gap + 1, level);

    // 2: SW[0] -> level 1, period 100; then SW[9] -> level 10, period 10
    SW = 10'b0000000001;
    repeat (5) step();
    check("t2_db_early", sw_db, 0);
    step();
    check("t2_db_rise", sw_db, 1);
    step();
    check("t2_level1", level, 1);
    next_tick(gap);
    check("t2_phase1", gap, 93);
    next_tick(gap);
    check("t2_period100", gap, 100);
    $display("t2: level=%0d period=%0d", level, gap);
    SW = 10'b1000000000;
    repeat (7) step();
    check("t2_level10", level, 10);
    next_tick(gap);
    check("t2_phase10", gap, 3);
    next_tick(gap);
    check("t2_period10", gap, 10);
    $display("t2: level=%0d period=%0d", level, gap);

    // 3: SW[3]+SW[7] -> level 4, period 70; short glitch on SW[1] is rejected
    SW = 10'b0010001000;
    repeat (7) step();
    check("t3_sw_db", sw_db, 10'h088);
    check("t3_level4", level, 4);
    next_tick(gap);
    check("t3_phase", gap, 63);
    next_tick(gap);
    check("t3_period70", gap, 70);
    SW[1] = 1'b1;
    repeat (3) step();
    SW[1] = 1'b0;
    repeat (10) step();
    check("t3_glitch_sw_db", sw_db, 10'h088);
    check("t3_glitch_level", level, 4);
    next_tick(gap);
    check("t3_glitch_phase", gap, 57);
    $display("t3: level=%0d sw_db=%h glitch rejected", level, sw_db);

    // 4: level 0 at cnt 50, jump to level 10 -> tick on the next cycle
    SW = '0;
    repeat (7) step();
    check("t4_level0", level, 0);
    next_tick(gap);
    check("t4_phase", gap, 103);
    repeat (43) step();
    SW = 10'b1000000000;
    repeat (6) step();
    check("t4_pre_level", level, 0);
    check("t4_pre_tick", tick, 0);
    step();
    check("t4_level10", level, 10);
    check("t4_no_tick_yet", tick, 0);
    step();
    check("t4_overshoot_tick", tick, 1);
    next_tick(gap);
    check("t4_period10", gap, 10);
    $display("t4: speed-up overshoot tick, then period=%0d", gap);

    // 5: reset mid-count clears everything; next tick 110 after release
    SW = '0;
    repeat (7) step();
    next_tick(gap);
    check("t5_phase", gap, 103);
    SW = 10'b0000000001;
    repeat (40) step();
    check("t5_pre_level", level, 1);
    RESET = 1'b1;
    SW    = '0;
    step();
    check("t5_rst_tick", tick, 0);
    check("t5_rst_level", level, 0);
    check("t5_rst_sw_db", sw_db, 0);
    RESET = 1'b0;
    next_tick(gap);
    check("t5_after_reset", gap, 110);
    $display("t5: reset mid-count, first tick after release gap=%0d", gap);

`ifdef SPEED_TICK_GEN_PAUSE_EN
    // 6: press pauses at cnt 6; second press resumes from the held phase
    KEY = 2'b01;
    repeat (6) step();
    KEY = 2'b11;
    quiet(500, seen);
    check("t6_paused_quiet", seen, 0);
    KEY = 2'b01;
    repeat (6) step();
    KEY = 2'b11;
    next_tick(gap);
    check("t6_resume_phase", gap, 105);
    next_tick(gap);
    check("t6_resume_period", gap, 110);
    $display("t6: pause/resume, resume gap=%0d", gap);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/speed_tick_gen.md
Name: speed_tick_gen

Overview:
- Upstream stage of the LED bouncer. Synchronises and debounces the ten speed switches and priority-encodes them to a speed level.
- Emits a one-cycle step strobe `tick` at the selected period. The bouncer shifts LEDG once per `tick` instead of running its own compare counter.
- Period mapping: SW[0] gives the slowest rate, SW[9] the fastest, no switch gives the default slowest-of-all rate.

Parameters:
- BASE_PERIOD, 1000000, clock cycles per period unit (20 ms at 50 MHz).
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a debounced input changes.
- CNT_W, 24, width of the period counter; must hold 11*BASE_PERIOD-1.
- DB_W, 20, width of each debounce counter; must hold DEBOUNCE_CYCLES.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- RESET  in  1  synchronous, active-high reset.
- SW  in  10  raw asynchronous slide switches, active-high.
- KEY  in  2  raw asynchronous pushbuttons, active-low. KEY[1] is used only with the optional feature; KEY[0] is unused.
- tick  out  1  one-cycle step strobe.
- level  out  4  current speed level, 0..10.
- sw_db  out  10  debounced switch levels.

Behaviour:
- Clock and reset: one clock, CLOCK_50. RESET is synchronous and active-high; every register clears on a CLOCK_50 edge while RESET=1.
- Reset values: tick=0, level=0, sw_db=0, period counter=0, synchronisers=0, debounce counters=0.
- Synchronisation: each raw input passes a 2-flop synchroniser, then a debounce sub-module.
- Debounce rule:
  - When the synchronised input differs from the stored value, increment the counter.
  - When it equals the stored value, clear the counter.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, toggle the stored value and clear the counter.
  - Net latency from a clean raw edge to sw_db change: 2 + DEBOUNCE_CYCLES cycles.
  - A glitch shorter than DEBOUNCE_CYCLES never changes sw_db.
- Priority encode (registered, one cycle after sw_db):
  - level = k+1 for the lowest index k with sw_db[k]=1.
  - level = 0 when sw_db is all zero.
  - Several switches on at once: lowest index wins (SW[0] beats SW[9]).
- Period: P = (11 - level) * BASE_PERIOD, giving 11, 10, …, 1 units for levels 0..10. Compute with the CNT_W-bit unsigned multiply of a 4-bit constant.
- Counter and tick:
  - If cnt >= P-1: tick=1 for exactly one cycle and cnt returns to 0 on the same edge.
  - Otherwise: cnt increments and tick=0.
  - tick is registered. The first tick after reset is asserted on the edge that ends cycle P counted from reset release.
- Period change mid-count: the new P applies immediately with no restart.
  - cnt < new P-1: counting continues.
  - cnt >= new P-1 (speed-up below current count): tick fires next cycle, then normal.
- RESET mid-count: cnt and tick clear on the next edge; no pending tick survives.
- tick is never asserted in two consecutive cycles unless P=1 (only if BASE_PERIOD=1).

Optional Feature:
- Macro: SPEED_TICK_GEN_PAUSE_EN.
- With the macro defined:
  - KEY[1] is synchronised and debounced like SW.
  - A debounced press (1→0 transition) toggles a `paused` flag; reset value 0.
  - While paused=1: cnt holds and tick=0. level and sw_db still track the switches.
  - Un-pause resumes from the held cnt.
  - A press coinciding with a would-be tick: the pause wins and tick is suppressed.
- Without the macro: KEY is ignored, no pause logic exists, and the tick behaviour is exactly as above.

Decomposition:
- Shared package speed_tick_pkg:
  - NUM_SW=10, LEVEL_W=4, MAX_LEVEL=10, PERIOD_UNITS_MAX=11.
  - Function period_of(level, base) returning the CNT_W-bit P.
- One sub-module, debounce_bit:
  - Contains the 2-flop synchroniser, DB_W counter and stored value; parameter DEBOUNCE_CYCLES; ports CLOCK_50, RESET, din, dout.
  - Instantiated once per SW bit, plus once for KEY[1] under the macro.
- The top level holds the encoder, the period counter and the optional pause flag.

Test Plan:
Simulate with BASE_PERIOD=10 and DEBOUNCE_CYCLES=4.
1. Reset then all switches off → level=0; tick pulses of width 1 every 110 cycles, first on cycle 110 after reset release.
2. SW=10'b0000000001 (SW[0] only) held → sw_db[0] rises 6 cycles after the edge; level=1; tick period 100. Then SW=10'b1000000000 (SW[9] only) → level=10; period 10.
3. SW[3] and SW[7] both on → level=4, period 70. A 3-cycle glitch on SW[1] → sw_db and level unchanged.
4. Level 0 with cnt at 50, switch to level 10 (P=10) → tick on the next cycle after level updates, then every 10 cycles.
5. Assert RESET for 1 cycle at cnt=40 → tick=0 and level=0 next edge; next tick 110 cycles after release.
6. With SPEED_TICK_GEN_PAUSE_EN: KEY[1] low for 6 cycles → paused; no tick for 500 cycles with cnt frozen. A second press → ticks resume at the held phase.
